// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Definitions shared by the multicycle MIPS datapath and its control FSM /
// ALU decoder:
//   - ALU control codes (alucontrol encoding)
//   - next-PC and ALU-B select encodings
//   - opcode constants for the controller
//   - register-file geometry and a sign-extension helper
// ---------------------------------------------------------------------------
package mips_pkg;

    // Register-file geometry
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    // ALU control codes. Codes outside this set make the ALU return zero,
    // which is why these are plain constants rather than a closed enum.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Next-PC source select
    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pcsrc_e;

    // ALU B-operand select
    typedef enum logic [1:0] {
        SRCB_REG   = 2'b00,
        SRCB_FOUR  = 2'b01,
        SRCB_IMM   = 2'b10,
        SRCB_IMMSH = 2'b11
    } srcb_e;

    // Opcodes decoded by the main controller
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Sign-extend a 16-bit immediate to a 32-bit word
    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mc_datapath_if.sv
// ---------------------------------------------------------------------------
// mc_datapath_if
// Bundle between the control FSM / memory side and the multicycle datapath.
//   Controls (controller -> datapath): IorD, IRwrite, memtoreg, branch,
//     pcwrite, regwrite, regdst, alusrcA, alusrcB[1:0], pcsrc[1:0],
//     alucontrol[2:0]
//   Memory:   readdata (memory -> datapath), adr / writedata (datapath -> memory)
//   Status (datapath -> controller): op[5:0], funct[5:0], zero
// Modports:
//   master - controller/memory side
//   slave  - the datapath
// ---------------------------------------------------------------------------
interface mc_datapath_if #(
    parameter int WIDTH = 32
) ();

    logic             IorD;
    logic             IRwrite;
    logic             memtoreg;
    logic             branch;
    logic             pcwrite;
    logic             regwrite;
    logic             regdst;
    logic             alusrcA;
    logic [1:0]       alusrcB;
    logic [1:0]       pcsrc;
    logic [2:0]       alucontrol;
    logic [WIDTH-1:0] readdata;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] writedata;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;

    modport master (
        output IorD, IRwrite, memtoreg, branch, pcwrite, regwrite, regdst,
               alusrcA, alusrcB, pcsrc, alucontrol, readdata,
        input  adr, writedata, op, funct, zero
    );

    modport slave (
        input  IorD, IRwrite, memtoreg, branch, pcwrite, regwrite, regdst,
               alusrcA, alusrcB, pcsrc, alucontrol, readdata,
        output adr, writedata, op, funct, zero
    );

endinterface

// File: rtl/mc_datapath_regfile.sv
// ---------------------------------------------------------------------------
// regfile
// 32 x 32 register file, two combinational read ports, one write port.
//   clk, reset_n   clock, asynchronous active-low reset (clears all entries)
//   ra1/rd1        read port 1
//   ra2/rd2        read port 2
//   we, wa, wd     write port, written on the rising edge when we = 1
//   ra3/rd3        third read port, only with MC_DATAPATH_DEBUG_EN defined
// Register 0 has no storage and always reads zero, so writes to it vanish.
// Reads are combinational from the stored value: a write lands at the edge,
// so a same-cycle read still sees the old contents.
// ---------------------------------------------------------------------------
module regfile
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wa,
    input  logic [31:0]           wd,
    output logic [31:0]           rd1,
    output logic [31:0]           rd2
`ifdef MC_DATAPATH_DEBUG_EN
    ,
    input  logic [REG_ADDR_W-1:0] ra3,
    output logic [31:0]           rd3
`endif
);

    logic [31:0] rf_words [NUM_REGS];

    assign rf_words[0] = '0;

    // Each entry needs its own async clear, so the array is built as
    // individual registers rather than a RAM.
    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_entry
            logic [31:0] entry_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    entry_reg <= '0;
                end else if (we && (wa == REG_ADDR_W'(gi))) begin
                    entry_reg <= wd;
                end
            end

            assign rf_words[gi] = entry_reg;
        end
    endgenerate

    assign rd1 = rf_words[ra1];
    assign rd2 = rf_words[ra2];

`ifdef MC_DATAPATH_DEBUG_EN
    assign rd3 = rf_words[ra3];
`endif

endmodule

// File: rtl/mc_datapath.sv
// ---------------------------------------------------------------------------
// mc_datapath
// Multicycle MIPS datapath. Holds PC, IR, MDR, A, B, ALUOut and the register
// file, drives the unified instruction/data memory port and returns
// op/funct/zero to the control FSM and ALU decoder.
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   bus       mc_datapath_if.slave: control strobes in, readdata in,
//             adr/writedata out, op/funct/zero out
//   dbg_addr  register-file debug read address   (MC_DATAPATH_DEBUG_EN only)
//   dbg_data  register-file debug read data      (MC_DATAPATH_DEBUG_EN only)
// Parameters:
//   WIDTH     datapath width, only 32 is supported
//   RESET_PC  PC value after reset
// Optional feature macro: MC_DATAPATH_DEBUG_EN adds the debug read port.
// ---------------------------------------------------------------------------
module mc_datapath
    import mips_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic clk,
    input  logic reset_n,
    mc_datapath_if.slave bus
`ifdef MC_DATAPATH_DEBUG_EN
    ,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]      dbg_data
`endif
);

    // Architectural / non-architectural state
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] ir_reg;
    logic [WIDTH-1:0] mdr_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] aluout_reg;

    // Combinational datapath nets
    logic [WIDTH-1:0]      rd1;
    logic [WIDTH-1:0]      rd2;
    logic [WIDTH-1:0]      signimm;
    logic [WIDTH-1:0]      src_a;
    logic [WIDTH-1:0]      src_b;
    logic [WIDTH-1:0]      alu_result;
    logic [WIDTH-1:0]      pc_next;
    logic [WIDTH-1:0]      rf_wd;
    logic [REG_ADDR_W-1:0] rf_wa;
    logic                  zero_flag;
    logic                  pcen;

    // Instruction fields
    assign signimm = sign_ext16(ir_reg[15:0]);

    // ALU operand selection
    always_comb begin
        src_a = bus.alusrcA ? a_reg : pc_reg;
    end

    always_comb begin
        src_b = b_reg;
        case (srcb_e'(bus.alusrcB))
            SRCB_REG:   src_b = b_reg;
            SRCB_FOUR:  src_b = WIDTH'(4);
            SRCB_IMM:   src_b = signimm;
            SRCB_IMMSH: src_b = {signimm[WIDTH-3:0], 2'b00};
            default:    src_b = b_reg;
        endcase
    end

    // ALU: add/sub wrap, slt is a signed compare, unknown codes give zero
    always_comb begin
        alu_result = '0;
        case (bus.alucontrol)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {{(WIDTH-1){1'b0}},
                                   ($signed(src_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
    end

    assign zero_flag = (alu_result == '0);

    // Next PC. The reserved select reloads the current PC, so a stray
    // pcen with pcsrc = 11 leaves the PC where it is.
    always_comb begin
        pc_next = pc_reg;
        case (pcsrc_e'(bus.pcsrc))
            PCSRC_ALU:    pc_next = alu_result;
            PCSRC_ALUOUT: pc_next = aluout_reg;
            PCSRC_JUMP:   pc_next = {pc_reg[WIDTH-1:WIDTH-4], ir_reg[25:0], 2'b00};
            PCSRC_RSVD:   pc_next = pc_reg;
            default:      pc_next = pc_reg;
        endcase
    end

    assign pcen = bus.pcwrite | (bus.branch & zero_flag);

    // Write address/data come from the IR and MDR as they stand before the
    // edge, so an IR load in the same cycle does not redirect the write.
    assign rf_wa = bus.regdst ? ir_reg[15:11] : ir_reg[20:16];
    assign rf_wd = bus.memtoreg ? mdr_reg : aluout_reg;

    regfile u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .ra1     (ir_reg[25:21]),
        .ra2     (ir_reg[20:16]),
        .we      (bus.regwrite),
        .wa      (rf_wa),
        .wd      (rf_wd),
        .rd1     (rd1),
        .rd2     (rd2)
`ifdef MC_DATAPATH_DEBUG_EN
        ,
        .ra3     (dbg_addr),
        .rd3     (dbg_data)
`endif
    );

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg     <= RESET_PC;
            ir_reg     <= '0;
            mdr_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            aluout_reg <= '0;
        end else begin
            if (pcen) begin
                pc_reg <= pc_next;
            end
            if (bus.IRwrite) begin
                ir_reg <= bus.readdata;
            end
            mdr_reg    <= bus.readdata;
            a_reg      <= rd1;
            b_reg      <= rd2;
            aluout_reg <= alu_result;
        end
    end

    // Outputs
    assign bus.adr       = bus.IorD ? aluout_reg : pc_reg;
    assign bus.writedata = b_reg;
    assign bus.op        = ir_reg[31:26];
    assign bus.funct     = ir_reg[5:0];
    assign bus.zero      = zero_flag;

endmodule

// File: tb/tb_mc_datapath.sv
// ---------------------------------------------------------------------------
// tb_mc_datapath
// Directed, table-driven bench for mc_datapath. Each table row is one clock
// cycle: controls and readdata are applied on the falling edge, the rising
// edge updates state, and adr/op/funct/writedata/zero are compared on the
// following falling edge with the same controls still applied. A short
// hand-written sequence then covers asynchronous reset mid-cycle.
// ---------------------------------------------------------------------------
module tb_mc_datapath;

    logic clk;
    logic reset_n;

    mc_datapath_if #(.WIDTH(32)) bus_if ();

`ifdef MC_DATAPATH_DEBUG_EN
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
`endif

    mc_datapath #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if)
`ifdef MC_DATAPATH_DEBUG_EN
        ,
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  flags;   // {IorD, IRwrite, memtoreg, branch, pcwrite, regwrite, regdst, alusrcA}
        logic [1:0]  asb;
        logic [1:0]  pcs;
        logic [2:0]  alu;
        logic [31:0] rdata;
        logic [31:0] e_adr;
        logic [5:0]  e_op;
        logic [5:0]  e_funct;
        logic [31:0] e_wd;
        logic        e_zero;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic [7:0] flags, input logic [1:0] asb,
                       input logic [1:0] pcs, input logic [2:0] alu,
                       input logic [31:0] rdata, input logic [31:0] e_adr,
                       input logic [5:0] e_op, input logic [5:0] e_funct,
                       input logic [31:0] e_wd, input logic e_zero);
        vec_t v;
        v.flags = flags; v.asb = asb; v.pcs = pcs; v.alu = alu;
        v.rdata = rdata; v.e_adr = e_adr; v.e_op = e_op;
        v.e_funct = e_funct; v.e_wd = e_wd; v.e_zero = e_zero;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic drive(input logic [7:0] flags, input logic [1:0] asb,
                         input logic [1:0] pcs, input logic [2:0] alu,
                         input logic [31:0] rdata);
        {bus_if.IorD, bus_if.IRwrite, bus_if.memtoreg, bus_if.branch,
         bus_if.pcwrite, bus_if.regwrite, bus_if.regdst, bus_if.alusrcA} = flags;
        bus_if.alusrcB    = asb;
        bus_if.pcsrc      = pcs;
        bus_if.alucontrol = alu;
        bus_if.readdata   = rdata;
    endtask

    initial begin
        //   flags         asb    pcs    alu     readdata       adr            op     funct  wd             zero
        // fetch addi $8,$0,5 ; addi execute ; write rf[8] ; B picks up rf[8]
        add(8'b01001000, 2'b01, 2'b00, 3'b010, 32'h2008_0005, 32'h0000_0004, 6'h08, 6'h05, 32'h0000_0000, 1'b0);
        add(8'b10000001, 2'b10, 2'b00, 3'b010, 32'h0000_0000, 32'h0000_0005, 6'h08, 6'h05, 32'h0000_0000, 1'b0);
        add(8'b10000101, 2'b10, 2'b00, 3'b010, 32'h0000_0000, 32'h0000_0005, 6'h08, 6'h05, 32'h0000_0000, 1'b0);
        add(8'b10000001, 2'b10, 2'b00, 3'b010, 32'h0000_0000, 32'h0000_0005, 6'h08, 6'h05, 32'h0000_0005, 1'b0);
        // addi $9,$8,2 : A reads 5 from rf[8], rf[9] = 7
        add(8'b01001000, 2'b01, 2'b00, 3'b010, 32'h2109_0002, 32'h0000_0008, 6'h08, 6'h02, 32'h0000_0005, 1'b0);
        add(8'b10000001, 2'b10, 2'b00, 3'b010, 32'h0000_0000, 32'h0000_0002, 6'h08, 6'h02, 32'h0000_0000, 1'b0);
        add(8'b10000001, 2'b10, 2'b00, 3'b010, 32'h0000_0000, 32'h0000_0007, 6'h08, 6'h02, 32'h0000_0000, 1'b0);
        add(8'b10000101, 2'b10, 2'b00, 3'b010, 32'h0000_0000, 32'h0000_0007, 6'h08, 6'h02, 32'h0000_0000, 1'b0);
        // beq $9,$9 (taken to 0x40)
        add(8'b01001000, 2'b01, 2'b00, 3'b010, 32'h1129_000D, 32'h0000_000C, 6'h04, 6'h0D, 32'h0000_0007, 1'b0);
        add(8'b10000000, 2'b11, 2'b00, 3'b010, 32'h0000_0000, 32'h0000_0040, 6'h04, 6'h0D, 32'h0000_0007, 1'b0);
        add(8'b00010001, 2'b00, 2'b01, 3'b110, 32'h0000_0000, 32'h0000_0040, 6'h04, 6'h0D, 32'h0000_0007, 1'b1);
        // beq $8,$9 (not taken), then slt 5<7
        add(8'b01001000, 2'b01, 2'b00, 3'b010, 32'h1109_000D, 32'h0000_0044, 6'h04, 6'h0D, 32'h0000_0007, 1'b0);
        add(8'b10000000, 2'b11, 2'b00, 3'b010, 32'h0000_0000, 32'h0000_0078, 6'h04, 6'h0D, 32'h0000_0007, 1'b0);
        add(8'b00010001, 2'b00, 2'b01, 3'b110, 32'h0000_0000, 32'h0000_0044, 6'h04, 6'h0D, 32'h0000_0007, 1'b0);
        add(8'b10000001, 2'b00, 2'b00, 3'b111, 32'h0000_0000, 32'h0000_0001, 6'h04, 6'h0D, 32'h0000_0007, 1'b0);
        // lw-style: rf[10] = MDR = 0x1000_0008
        add(8'b01000000, 2'b01, 2'b00, 3'b010, 32'h8C0A_0000, 32'h0000_0044, 6'h23, 6'h00, 32'h0000_0007, 1'b0);
        add(8'b10000001, 2'b10, 2'b00, 3'b010, 32'h1000_0008, 32'h0000_0005, 6'h23, 6'h00, 32'h0000_0000, 1'b1);
        add(8'b10100101, 2'b10, 2'b00, 3'b010, 32'h0000_0000, 32'h0000_0000, 6'h23, 6'h00, 32'h0000_0000, 1'b1);
        // PC <= rf[10] via ALU, then jump to 0x1000_0040, then reserved pcsrc holds
        add(8'b11000001, 2'b10, 2'b00, 3'b010, 32'h0140_0000, 32'h0000_0000, 6'h00, 6'h00, 32'h1000_0008, 1'b1);
        add(8'b00000001, 2'b00, 2'b00, 3'b010, 32'h0000_0000, 32'h0000_0044, 6'h00, 6'h00, 32'h0000_0000, 1'b0);
        add(8'b00001001, 2'b00, 2'b00, 3'b010, 32'h0000_0000, 32'h1000_0008, 6'h00, 6'h00, 32'h0000_0000, 1'b0);
        add(8'b01000000, 2'b01, 2'b00, 3'b010, 32'h0800_0010, 32'h1000_0008, 6'h02, 6'h10, 32'h0000_0000, 1'b0);
        add(8'b00001000, 2'b01, 2'b10, 3'b010, 32'h0000_0000, 32'h1000_0040, 6'h02, 6'h10, 32'h0000_0000, 1'b0);
        add(8'b00001000, 2'b01, 2'b11, 3'b010, 32'h0000_0000, 32'h1000_0040, 6'h02, 6'h10, 32'h0000_0000, 1'b0);
        // write 0xFFFF_FFFF to $0 (regdst=1, rd=0), then A+B reads 0
        add(8'b01000000, 2'b01, 2'b00, 3'b010, 32'h0000_0001, 32'h1000_0040, 6'h00, 6'h01, 32'h0000_0000, 1'b0);
        add(8'b10000001, 2'b10, 2'b00, 3'b110, 32'h0000_0000, 32'hFFFF_FFFF, 6'h00, 6'h01, 32'h0000_0000, 1'b0);
        add(8'b10000111, 2'b10, 2'b00, 3'b110, 32'h0000_0000, 32'hFFFF_FFFF, 6'h00, 6'h01, 32'h0000_0000, 1'b0);
        add(8'b10000001, 2'b00, 2'b00, 3'b010, 32'h0000_0000, 32'h0000_0000, 6'h00, 6'h01, 32'h0000_0000, 1'b1);
        // rf[11] = -1 via MDR
        add(8'b01000000, 2'b01, 2'b00, 3'b010, 32'h8C0B_0000, 32'h1000_0040, 6'h23, 6'h00, 32'h0000_0000, 1'b0);
        add(8'b10000001, 2'b10, 2'b00, 3'b010, 32'hFFFF_FFFF, 32'h0000_0000, 6'h23, 6'h00, 32'h0000_0000, 1'b1);
        add(8'b10100101, 2'b10, 2'b00, 3'b010, 32'h0000_0000, 32'h0000_0000, 6'h23, 6'h00, 32'h0000_0000, 1'b1);
        // slt with A=-1, srcB=1 (signed -> 1); slt false; and/unknown/or
        add(8'b11000001, 2'b10, 2'b00, 3'b010, 32'h0160_0001, 32'h0000_0000, 6'h00, 6'h01, 32'hFFFF_FFFF, 1'b0);
        add(8'b10000001, 2'b10, 2'b00, 3'b111, 32'h0000_0000, 32'h0000_0001, 6'h00, 6'h01, 32'h0000_0000, 1'b0);
        add(8'b10000001, 2'b10, 2'b00, 3'b111, 32'h0000_0000, 32'h0000_0001, 6'h00, 6'h01, 32'h0000_0000, 1'b0);
        add(8'b10000000, 2'b00, 2'b00, 3'b111, 32'h0000_0000, 32'h0000_0000, 6'h00, 6'h01, 32'h0000_0000, 1'b1);
        add(8'b10000001, 2'b01, 2'b00, 3'b000, 32'h0000_0000, 32'h0000_0004, 6'h00, 6'h01, 32'h0000_0000, 1'b0);
        add(8'b10000001, 2'b01, 2'b00, 3'b011, 32'h0000_0000, 32'h0000_0000, 6'h00, 6'h01, 32'h0000_0000, 1'b1);
        add(8'b10000001, 2'b01, 2'b00, 3'b001, 32'h0000_0000, 32'hFFFF_FFFF, 6'h00, 6'h01, 32'h0000_0000, 1'b0);

        // ---------------- reset ----------------
        reset_n = 1'b0;
        drive(8'h00, 2'b00, 2'b00, 3'b000, 32'h0);
`ifdef MC_DATAPATH_DEBUG_EN
        dbg_addr = 5'd8;
`endif
        repeat (2) @(negedge clk);
        check("reset adr", bus_if.adr, 32'h0);
        check("reset op", 32'(bus_if.op), 32'h0);
        check("reset funct", 32'(bus_if.funct), 32'h0);
        check("reset writedata", bus_if.writedata, 32'h0);
        check("reset zero", 32'(bus_if.zero), 32'h1);
        reset_n = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].flags, vecs[i].asb, vecs[i].pcs, vecs[i].alu, vecs[i].rdata);
            @(posedge clk);
            @(negedge clk);
            $display("row %0d: adr=%h op=%h funct=%h wd=%h zero=%0b",
                     i, bus_if.adr, bus_if.op, bus_if.funct, bus_if.writedata, bus_if.zero);
            check($sformatf("row%0d adr", i), bus_if.adr, vecs[i].e_adr);
            check($sformatf("row%0d op", i), 32'(bus_if.op), 32'(vecs[i].e_op));
            check($sformatf("row%0d funct", i), 32'(bus_if.funct), 32'(vecs[i].e_funct));
            check($sformatf("row%0d writedata", i), bus_if.writedata, vecs[i].e_wd);
            check($sformatf("row%0d zero", i), 32'(bus_if.zero), 32'(vecs[i].e_zero));
        end

        // ---------------- async reset mid-cycle ----------------
`ifdef MC_DATAPATH_DEBUG_EN
        dbg_addr = 5'd11;
        #1;
        check("dbg rf11", dbg_data, 32'hFFFF_FFFF);
`endif
        drive(8'b10000000, 2'b00, 2'b00, 3'b000, 32'h0);
        #2;
        reset_n = 1'b0;
        #1;
        $display("async reset: adr(aluout)=%h op=%h", bus_if.adr, bus_if.op);
        check("async aluout", bus_if.adr, 32'h0);
        check("async op", 32'(bus_if.op), 32'h0);
        check("async funct", 32'(bus_if.funct), 32'h0);
        check("async writedata", bus_if.writedata, 32'h0);
        bus_if.IorD = 1'b0;
        #1;
        check("async pc", bus_if.adr, 32'h0);
`ifdef MC_DATAPATH_DEBUG_EN
        dbg_addr = 5'd8;
        #1;
        check("dbg rf8 reset", dbg_data, 32'h0);
`endif
        // Strobes active across an edge while reset is held: nothing loads
        drive(8'b01001100, 2'b01, 2'b00, 3'b010, 32'h2008_0005);
        @(posedge clk);
        @(negedge clk);
        check("held op", 32'(bus_if.op), 32'h0);
        check("held pc", bus_if.adr, 32'h0);
        drive(8'h00, 2'b00, 2'b00, 3'b000, 32'h0);
        reset_n = 1'b1;
        #1;
        check("release op", 32'(bus_if.op), 32'h0);

        // Fetch after release, then confirm rf[11] was cleared
        drive(8'b01001000, 2'b01, 2'b00, 3'b010, 32'h8C0B_0000);
        @(posedge clk);
        @(negedge clk);
        $display("post-reset fetch: adr=%h op=%h", bus_if.adr, bus_if.op);
        check("post fetch pc", bus_if.adr, 32'h0000_0004);
        check("post fetch op", 32'(bus_if.op), 32'h23);
        drive(8'b00000001, 2'b10, 2'b00, 3'b010, 32'h0);
        @(posedge clk);
        @(negedge clk);
        $display("post-reset rf11: wd=%h", bus_if.writedata);
        check("post rf11 cleared", bus_if.writedata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_datapath.md
Name: mc_datapath

Overview:
- Multicycle MIPS datapath, directly downstream of the main control FSM. It consumes the FSM's per-cycle control strobes and produces the opcode/funct fields and the ALU zero flag that the FSM and ALU decoder need.
- Holds the architectural and non-architectural state: PC, IR, MDR, A, B and ALUOut registers, plus the 32x32 register file.
- Drives the single unified instruction/data memory port.

Parameters:
- WIDTH, 32, datapath word width; only 32 is supported.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- IorD  in  1  memory address select: 0 = PC, 1 = ALUOut
- IRwrite  in  1  load IR from readdata
- memtoreg  in  1  register-file write data select: 0 = ALUOut, 1 = MDR
- branch  in  1  conditional PC update on zero
- pcwrite  in  1  unconditional PC update
- regwrite  in  1  register-file write enable
- regdst  in  1  write-register select: 0 = rt, 1 = rd
- alusrcA  in  1  ALU A select: 0 = PC, 1 = A register
- alusrcB  in  2  ALU B select: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  in  2  next-PC select
- alucontrol  in  3  ALU operation, driven by the ALU decoder
- readdata  in  32  memory read data
- adr  out  32  memory address
- writedata  out  32  memory write data; always equals the B register
- op  out  6  IR[31:26]
- funct  out  6  IR[5:0]
- zero  out  1  combinational flag, asserted when the ALU result is 0

Behaviour:
- Reset, async on reset_n low:
  - PC = RESET_PC.
  - IR, MDR, A, B, ALUOut = 0.
  - All 32 register-file entries = 0.
  - Consequence: op = funct = 0 and adr = RESET_PC.
- Reset deasserting mid-instruction: all state restarts from the reset values. No partial writes may occur while reset_n is low.
- Register updates on posedge clk:
  - PC loads next_pc when pcen = pcwrite | (branch & zero).
  - IR loads readdata only when IRwrite = 1.
  - MDR, A, B and ALUOut load every cycle:
    - MDR = readdata.
    - A = rf[IR[25:21]], B = rf[IR[20:16]].
    - ALUOut = ALU result.
- next_pc by pcsrc:
  - 00: ALU result.
  - 01: ALUOut.
  - 10: {PC[31:28], IR[25:0], 2'b00}.
  - 11: reserved; PC holds its current value even if pcen = 1.
- Combinational paths:
  - adr = IorD ? ALUOut : PC.
  - signimm = sign-extended IR[15:0].
  - srcA and srcB are selected per alusrcA and alusrcB.
- ALU, alucontrol encoding:
  - 010 add; 110 sub; 000 and; 001 or.
  - 111 slt: signed compare, result is 1 or 0.
  - Any other code: result 0.
  - Add and sub wrap modulo 2^32; no overflow flag.
- Register file:
  - Two combinational read ports, one write port written on posedge when regwrite = 1.
  - Write address = regdst ? IR[15:11] : IR[20:16].
  - Write data = memtoreg ? MDR : ALUOut.
  - Register 0 always reads 0; writes to it are discarded.
  - Reading a register in the same cycle it is written returns the old value. The new value is visible from the next cycle.
- Simultaneous IRwrite and regwrite: the write address is taken from the pre-edge IR.
- Latency: the ALU output is registered into ALUOut after 1 cycle. A memory read reaches MDR 1 cycle after adr is presented.

Optional Feature:
- Macro: MC_DATAPATH_DEBUG_EN.
- When defined, two extra ports are added:
  - dbg_addr  in  5  register-file debug read address.
  - dbg_data  out  32  combinational third read port; dbg_addr = 0 returns 0.
- When undefined, these ports and the third read port do not exist; the port list is exactly as above.

Decomposition:
- Shared package mips_pkg holds:
  - ALU control codes: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT.
  - Select encodings: PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP; SRCB_REG, SRCB_FOUR, SRCB_IMM, SRCB_IMMSH.
  - Opcode constants shared with the controller.
- One sub-module, regfile (32x32, 2R1W, async reset). The ALU and muxes stay inline.

Test Plan:
1. Reset, then release; IorD=0, alusrcA=0, alusrcB=01, alucontrol=010, pcsrc=00, pcwrite=1, IRwrite=1, readdata=32'h2008_0005 → after the edge: PC=4, op=6'b001000, adr=4.
2. addi path with IR=32'h2008_0005:
   - alusrcA=1, alusrcB=10, add → ALUOut=5.
   - Next cycle regwrite=1, regdst=0, memtoreg=0 → rf[8]=5.
   - Then A reads 5 when rs=8.
3. beq: A=B=7, alucontrol=110 → zero=1. With branch=1, pcwrite=0, pcsrc=01, ALUOut=32'h40 → PC=32'h40. With A≠B, PC is unchanged.
4. Jump: PC=32'h1000_0008, IR=32'h0800_0010, pcsrc=10, pcwrite=1 → PC=32'h1000_0040.
5. Write to $0 (regdst=1, rd=0, ALUOut=32'hFFFF_FFFF, regwrite=1) → A reads 0. Separately, slt with A=-1, B=1 → result 1.
6. Assert reset_n low mid-cycle with PC=32'h80 → PC, IR and ALUOut are 0 immediately, without waiting for a clock edge. Under MC_DATAPATH_DEBUG_EN, dbg_data reads 0 for dbg_addr=8.
